// File: rtl/avg_filter_scheduler.sv
// ============================================================================
// Module   : avg_filter_scheduler
// Brief    : Round-robin shared moving-average engine with per-channel context.
// Revision : 1.0
// ============================================================================
`default_nettype none

module avg_filter_scheduler #(
    parameter  int N_CH     = 4,
    parameter  int DW       = 8,
    parameter  int LOG2_WIN = 2,
    localparam int CHW      = $clog2(N_CH)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_flush,
    input  logic [N_CH-1:0]    i_valid,
    input  logic [N_CH*DW-1:0] i_data,
    output logic [N_CH-1:0]    o_ready,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DW-1:0]      o_data,
    output logic [CHW-1:0]     o_ch,
    output logic               o_primed
);

    localparam int WIN = 1 << LOG2_WIN;
    localparam int SW  = DW + LOG2_WIN;
    localparam int FW  = LOG2_WIN + 1;

    logic [CHW-1:0]      r_ptr;
    logic [DW-1:0]       r_hist [N_CH][WIN];
    logic [SW-1:0]       r_sum  [N_CH];
    logic [LOG2_WIN-1:0] r_idx  [N_CH];
    logic [FW-1:0]       r_fill [N_CH];
    logic                r_valid;
    logic [DW-1:0]       r_data;
    logic [CHW-1:0]      r_ch;
    logic                r_primed;

    logic [N_CH-1:0]     w_grant;
    logic [CHW-1:0]      w_gidx;
    logic                w_found;
    logic                w_block;
    logic                w_acc;
    logic [DW-1:0]       w_x;
    logic [DW-1:0]       w_old;
    logic [SW-1:0]       w_sum_new;
    logic [FW-1:0]       w_fill_new;
    logic [CHW-1:0]      w_ptr_next;
    int                  w_k;

    // First requester at or after the pointer, wrapping modulo N_CH.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int i = 0; i < N_CH; i++) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= N_CH) begin
                w_k = w_k - N_CH;
            end
            if (!w_found && i_valid[w_k]) begin
                w_found        = 1'b1;
                w_grant[w_k]   = 1'b1;
                w_gidx         = CHW'(w_k);
            end
        end
    end

    // Reset is folded in so no grant leaks out while the context is cleared.
    assign w_block = !i_reset_n || i_flush || (r_valid && !i_ready);
    assign o_ready = w_block ? '0 : w_grant;
    assign w_acc   = |o_ready;

    assign w_x        = i_data[w_gidx*DW +: DW];
    assign w_old      = r_hist[w_gidx][r_idx[w_gidx]];
    assign w_sum_new  = r_sum[w_gidx] - SW'(w_old) + SW'(w_x);
    assign w_fill_new = (r_fill[w_gidx] == FW'(WIN)) ? r_fill[w_gidx]
                                                     : r_fill[w_gidx] + FW'(1);
    assign w_ptr_next = (w_gidx == CHW'(N_CH - 1)) ? '0 : w_gidx + CHW'(1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_sum[c]  <= '0;
                r_idx[c]  <= '0;
                r_fill[c] <= '0;
                for (int j = 0; j < WIN; j++) begin
                    r_hist[c][j] <= '0;
                end
            end
        end else if (i_flush) begin
            r_ptr <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_sum[c]  <= '0;
                r_idx[c]  <= '0;
                r_fill[c] <= '0;
                for (int j = 0; j < WIN; j++) begin
                    r_hist[c][j] <= '0;
                end
            end
        end else if (w_acc) begin
            r_ptr                       <= w_ptr_next;
            r_sum[w_gidx]               <= w_sum_new;
            r_hist[w_gidx][r_idx[w_gidx]] <= w_x;
            r_idx[w_gidx]               <= r_idx[w_gidx] + LOG2_WIN'(1);
            r_fill[w_gidx]              <= w_fill_new;
        end
    end

    // A new accept reloads the result even on the cycle the old one drains.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_ch     <= '0;
            r_primed <= 1'b0;
        end else if (i_flush) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_ch     <= '0;
            r_primed <= 1'b0;
        end else if (w_acc) begin
            r_valid  <= 1'b1;
            r_data   <= w_sum_new[SW-1:LOG2_WIN];
            r_ch     <= w_gidx;
            r_primed <= (w_fill_new == FW'(WIN));
        end else if (i_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_ch     = r_ch;
    assign o_primed = r_primed;

endmodule

`default_nettype wire

// File: tb/tb_avg_filter_scheduler.sv
// ============================================================================
// Module   : tb_avg_filter_scheduler
// Brief    : Directed bench with a queue-based window model checked every cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_avg_filter_scheduler;

    localparam int N_CH     = 4;
    localparam int DW       = 8;
    localparam int LOG2_WIN = 2;
    localparam int WIN      = 1 << LOG2_WIN;
    localparam int CHW      = $clog2(N_CH);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic [N_CH-1:0]    valid;
    logic [N_CH*DW-1:0] data;
    logic [N_CH-1:0]    o_ready;
    logic               o_valid;
    logic               rdy;
    logic [DW-1:0]      o_data;
    logic [CHW-1:0]     o_ch;
    logic               o_primed;

    int checks = 0;
    int errors = 0;

    // Window model: last WIN samples per channel, empty slots count as zero.
    int mhist [N_CH][$];
    int mfill [N_CH];
    int mptr    = 0;
    int e_valid = 0;
    int e_data  = 0;
    int e_ch    = 0;
    int e_pr    = 0;
    int e_known = 1;

    int log_d [$];
    int log_c [$];
    int log_p [$];

    avg_filter_scheduler #(.N_CH(N_CH), .DW(DW), .LOG2_WIN(LOG2_WIN)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_flush  (flush),
        .i_valid  (valid),
        .i_data   (data),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .i_ready  (rdy),
        .o_data   (o_data),
        .o_ch     (o_ch),
        .o_primed (o_primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < N_CH; c++) begin
            mhist[c].delete();
            mfill[c] = 0;
        end
        mptr = 0; e_valid = 0; e_data = 0; e_ch = 0; e_pr = 0; e_known = 1;
    endtask

    always @(negedge clk) begin
        int g, s, x, exp_rdy;
        if (!rst_n) begin
            chk("rst_ready", int'(o_ready), 0);
            chk("rst_valid", int'(o_valid), 0);
            chk("rst_data",  int'(o_data), 0);
            chk("rst_ch",    int'(o_ch), 0);
            chk("rst_primed", int'(o_primed), 0);
            model_clear();
        end else begin
            g = -1;
            if (!flush && !(e_valid != 0 && !rdy)) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (g < 0 && valid[(mptr + i) % N_CH]) g = (mptr + i) % N_CH;
                end
            end
            exp_rdy = (g >= 0) ? (1 << g) : 0;
            chk("m_ready", int'(o_ready), exp_rdy);
            chk("m_valid", int'(o_valid), e_valid);
            if (e_known != 0) begin
                chk("m_data",   int'(o_data), e_data);
                chk("m_ch",     int'(o_ch), e_ch);
                chk("m_primed", int'(o_primed), e_pr);
            end
            if (o_valid && rdy) begin
                log_d.push_back(int'(o_data));
                log_c.push_back(int'(o_ch));
                log_p.push_back(int'(o_primed));
            end
            if (flush) begin
                model_clear();
            end else if (g >= 0) begin
                x = int'(data[g*DW +: DW]);
                mhist[g].push_back(x);
                if (mhist[g].size() > WIN) void'(mhist[g].pop_front());
                s = 0;
                foreach (mhist[g][j]) s += mhist[g][j];
                mfill[g]++;
                e_data  = s / WIN;
                e_ch    = g;
                e_pr    = (mfill[g] >= WIN) ? 1 : 0;
                e_valid = 1;
                e_known = 1;
                mptr    = (g + 1) % N_CH;
            end else if (e_valid != 0 && rdy) begin
                e_valid = 0;
                e_known = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_d.delete(); log_c.delete(); log_p.delete();
    endtask

    task automatic chk_log(input string nm, input int i, input int c, input int d, input int p);
        if (i >= log_d.size()) begin
            chk({nm, "_missing"}, log_d.size(), i + 1);
        end else begin
            chk({nm, "_ch"}, log_c[i], c);
            chk({nm, "_data"}, log_d[i], d);
            chk({nm, "_primed"}, log_p[i], p);
        end
    endtask

    task automatic run_t1(input string nm);
        int smp [5] = '{4, 8, 12, 16, 20};
        int exd [5] = '{1, 3, 6, 10, 14};
        int exp_pr [5] = '{0, 0, 0, 1, 1};
        clear_log();
        for (int i = 0; i < 5; i++) begin
            valid = 4'b0001;
            data  = '0;
            data[0 +: DW] = DW'(smp[i]);
            step();
        end
        valid = '0;
        step(); step();
        chk({nm, "_count"}, log_d.size(), 5);
        for (int i = 0; i < 5; i++) chk_log(nm, i, 0, exd[i], exp_pr[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int gexp [6] = '{1, 2, 4, 8, 1, 2};
        int cexp [6] = '{0, 1, 2, 3, 0, 1};
        int dexp [6] = '{2, 5, 7, 10, 5, 10};
        int t4d  [5] = '{63, 127, 191, 255, 255};
        int t4p  [5] = '{0, 0, 0, 1, 1};
        rst_n = 1'b0; flush = 1'b0; rdy = 1'b1; data = '0;
        valid = 4'hF;
        #12;
        chk("reset_ready_gated", int'(o_ready), 0);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_data", int'(o_data), 0);
        valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_t1("t1");

        // T2: all channels requesting, round-robin from pointer 0.
        flush = 1'b1; step(); flush = 1'b0;
        clear_log();
        valid = 4'hF;
        data  = {8'd40, 8'd30, 8'd20, 8'd10};
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t2_grant", int'(o_ready), gexp[i]);
            step();
        end

        // T3: stall holds the last result (ch1, two samples of 20 -> 10).
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_ready", int'(o_ready), 0);
            chk("t3_valid", int'(o_valid), 1);
            chk("t3_data", int'(o_data), 10);
            chk("t3_ch", int'(o_ch), 1);
            step();
        end
        rdy = 1'b1; valid = '0;
        step(); step(); step();
        chk("t2_count", log_d.size(), 6);
        for (int i = 0; i < 6; i++) chk_log("t2", i, cexp[i], dexp[i], 0);

        // T4: full-scale samples must not wrap the running sum.
        flush = 1'b1; step(); flush = 1'b0;
        clear_log();
        for (int i = 0; i < 5; i++) begin
            valid = 4'b0100;
            data  = '0;
            data[2*DW +: DW] = 8'd255;
            step();
        end
        valid = '0;
        step(); step();
        chk("t4_count", log_d.size(), 5);
        for (int i = 0; i < 5; i++) chk_log("t4", i, 2, t4d[i], t4p[i]);

        // T5: flush mid-stream clears history and pointer.
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid = 4'b0010;
            data  = '0;
            data[DW +: DW] = DW'(5 + i);
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_log();
        valid = 4'b1001;
        #1;
        chk("t5_ptr_restart", int'(o_ready), 1);
        chk("t5_valid_cleared", int'(o_valid), 0);
        valid = 4'b0010;
        data  = '0;
        data[DW +: DW] = 8'd8;
        step();
        valid = '0;
        step(); step();
        chk("t5_count", log_d.size(), 1);
        chk_log("t5", 0, 1, 2, 0);

        // T6: asynchronous reset between edges, then T1 again from scratch.
        flush = 1'b1; step(); flush = 1'b0;
        valid = 4'b0001;
        data  = '0;
        data[0 +: DW] = 8'd4;
        step();
        data[0 +: DW] = 8'd8;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(o_valid), 0);
        chk("t6_async_data", int'(o_data), 0);
        chk("t6_async_ready", int'(o_ready), 0);
        step(); step();
        rst_n = 1'b1;
        valid = '0;
        run_t1("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
